// File: rtl/fetch_stage.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | fetch_stage: PC owner, single-outstanding instruction fetch into IF/ID  |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h8002_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] ir_out,
  output logic        valid_out
);

  typedef enum logic [2:0] {
    BOOT  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] redirect_tgt;
  logic [31:0] pc_seq;

  assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
  assign pc_seq       = pc + 32'd4;

  // mem_req is registered, so it is raised on every transition into FETCH
  // together with the address that FETCH will present.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= BOOT;
      pc        <= RESET_PC;
      mem_req   <= 1'b0;
      mem_addr  <= 32'd0;
      pc_out    <= 32'd0;
      ir_out    <= 32'd0;
      valid_out <= 1'b0;
    end else begin
      mem_req <= 1'b0;
      case (state)
        BOOT: begin
          state    <= FETCH;
          mem_req  <= 1'b1;
          mem_addr <= pc;
        end

        FETCH: begin
          valid_out <= 1'b0;
          if (redirect_valid) begin
            pc    <= redirect_tgt;
            state <= DRAIN;
          end else begin
            state <= WAIT;
          end
        end

        WAIT: begin
          valid_out <= 1'b0;
          if (redirect_valid) begin
            pc <= redirect_tgt;
            if (mem_ack) begin
              state    <= FETCH;
              mem_req  <= 1'b1;
              mem_addr <= redirect_tgt;
            end else begin
              state <= DRAIN;
            end
          end else if (mem_ack) begin
            pc_out    <= pc;
            ir_out    <= mem_rdata;
            valid_out <= 1'b1;
            pc        <= pc_seq;
            mem_addr  <= pc_seq;
            if (stall) begin
              state <= HOLD;
            end else begin
              state   <= FETCH;
              mem_req <= 1'b1;
            end
          end
        end

        HOLD: begin
          if (redirect_valid) begin
            valid_out <= 1'b0;
            pc        <= redirect_tgt;
            state     <= FETCH;
            mem_req   <= 1'b1;
            mem_addr  <= redirect_tgt;
          end else if (!stall) begin
            valid_out <= 1'b0;
            state     <= FETCH;
            mem_req   <= 1'b1;
            mem_addr  <= pc;
          end
        end

        DRAIN: begin
          valid_out <= 1'b0;
          if (redirect_valid) begin
            pc <= redirect_tgt;
          end
          // A redirect landing on the draining ack must steer the refetch too.
          if (mem_ack) begin
            state    <= FETCH;
            mem_req  <= 1'b1;
            mem_addr <= redirect_valid ? redirect_tgt : pc;
          end
        end

        default: begin
          state <= BOOT;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_fetch_stage: randomized stall/redirect/ack stimulus, scoreboard check |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h8002_0000;
  localparam logic [31:0] WRAP_PC  = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic [31:0] pc_out;
  logic [31:0] ir_out;
  logic        valid_out;

  logic        w_req;
  logic [31:0] w_addr;
  logic        w_ack;
  logic [31:0] w_pc;
  logic [31:0] w_ir;
  logic        w_valid;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .pc_out         (pc_out),
    .ir_out         (ir_out),
    .valid_out      (valid_out)
  );

  fetch_stage #(.RESET_PC(WRAP_PC)) dut_wrap (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (1'b0),
    .redirect_valid (1'b0),
    .redirect_pc    (32'd0),
    .mem_req        (w_req),
    .mem_addr       (w_addr),
    .mem_ack        (w_ack),
    .mem_rdata      (32'h1234_5678),
    .pc_out         (w_pc),
    .ir_out         (w_ir),
    .valid_out      (w_valid)
  );

  // Zero-wait memory for the wrap instance: ack exactly one cycle after req.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) w_ack <= 1'b0;
    else        w_ack <= w_req;
  end

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
    bit          held;
  } item_t;

  item_t       exp_q[$];
  item_t       cur;
  logic [31:0] exp_pc = RESET_PC;
  logic [31:0] req_addr = 32'd0;
  bit          outstanding = 1'b0;
  bit          tainted = 1'b0;
  bit          exp_valid = 1'b0;
  bit          prev_exp = 1'b0;
  bit          started = 1'b0;
  int          idle = 0;
  int          ack_cnt = 0;
  logic [31:0] wrap_addrs[$];
  logic [31:0] wrap_first_pc = 32'hxxxx_xxxx;
  bit          wrap_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_req"},   32'(mem_req),   32'd0);
    check({tag, "_mem_addr"},  mem_addr,       32'd0);
    check({tag, "_pc_out"},    pc_out,         32'd0);
    check({tag, "_ir_out"},    ir_out,         32'd0);
    check({tag, "_valid_out"}, 32'(valid_out), 32'd0);
  endtask

  // Reference model: a fetch is delivered only if no redirect was seen from
  // its request cycle through its ack cycle; delivered fetches advance the PC
  // by 4, redirects replace it. Held deliveries persist while stall stays high.
  always @(negedge clk) begin
    bit nv;
    nv = 1'b0;
    if (!rst_n) begin
      exp_q.delete();
      exp_pc      = RESET_PC;
      outstanding = 1'b0;
      tainted     = 1'b0;
      exp_valid   = 1'b0;
      prev_exp    = 1'b0;
      started     = 1'b0;
      idle        = 0;
    end else begin
      check("valid_out", 32'(valid_out), 32'(exp_valid));
      if (exp_valid && !prev_exp) begin
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL scoreboard_pop: got empty queue, expected a pending instruction at %0t", $time);
        end else begin
          cur = exp_q.pop_front();
          check("pc_out", pc_out, cur.pc);
          check("ir_out", ir_out, cur.ir);
        end
      end else if (exp_valid) begin
        check("pc_out_hold", pc_out, cur.pc);
        check("ir_out_hold", ir_out, cur.ir);
      end
      prev_exp = exp_valid;
      nv = exp_valid && cur.held && stall && !redirect_valid;

      if (mem_req) begin
        check("mem_addr", mem_addr, exp_pc);
        check("one_outstanding", 32'(outstanding), 32'd0);
        check("no_req_in_hold", 32'(exp_valid && cur.held), 32'd0);
        outstanding = 1'b1;
        tainted     = 1'b0;
        req_addr    = exp_pc;
        started     = 1'b1;
        idle        = 0;
      end else if (!(exp_valid && cur.held)) begin
        idle++;
        if (idle > 12) begin
          checks++;
          fails++;
          $display("FAIL fetch_progress: got %0d cycles without mem_req, expected at most 12", idle);
          idle = 0;
        end
      end

      if (redirect_valid) begin
        exp_pc = redirect_pc & 32'hFFFF_FFFC;
        if (outstanding) tainted = 1'b1;
      end
      if (mem_ack && outstanding) begin
        outstanding = 1'b0;
        if (!tainted) begin
          exp_q.push_back('{pc: req_addr, ir: mem_rdata, held: stall});
          exp_pc = req_addr + 32'd4;
          nv     = 1'b1;
        end
      end
      exp_valid = nv;
    end
  end

  always @(negedge clk) begin
    if (rst_n && w_req && wrap_addrs.size() < 2) wrap_addrs.push_back(w_addr);
    if (rst_n && w_valid && !wrap_seen) begin
      wrap_first_pc = w_pc;
      wrap_seen     = 1'b1;
    end
  end

  // One cycle of stimulus plus the random-latency memory responder.
  task automatic drive_cycle(input bit quiet);
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    if (mem_req) begin
      ack_cnt = $urandom_range(1, 3);
    end else if (ack_cnt > 0) begin
      ack_cnt--;
      if (ack_cnt == 0) begin
        mem_ack   = 1'b1;
        mem_rdata = $urandom;
      end
    end
    if (quiet) begin
      stall          = 1'b0;
      redirect_valid = 1'b0;
    end else begin
      if ($urandom_range(0, 3) == 0) stall = ~stall;
      redirect_valid = started && ($urandom_range(0, 9) == 0);
      redirect_pc    = ($urandom_range(0, 7) == 0) ? (WRAP_PC | 32'($urandom_range(0, 3)))
                                                   : $urandom;
    end
  endtask

  // Release mid-cycle and present a stale ack to the BOOT cycle.
  task automatic reset_release();
    @(posedge clk);
    #2;
    rst_n     = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    reset_release();
    repeat (8) drive_cycle(1'b1);
    repeat (1500) drive_cycle(1'b0);

    if (wrap_addrs.size() < 2) begin
      checks++;
      fails++;
      $display("FAIL wrap_fetch: got %0d requests, expected at least 2", wrap_addrs.size());
    end else begin
      check("wrap_addr0", wrap_addrs[0], WRAP_PC);
      check("wrap_addr1", wrap_addrs[1], 32'h0000_0000);
    end
    check("wrap_pc_out", wrap_first_pc, WRAP_PC);

    for (int i = 0; i < 20 && !mem_req; i++) drive_cycle(1'b1);
    @(posedge clk);
    #3;
    rst_n          = 1'b0;
    ack_cnt        = 0;
    mem_ack        = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    repeat (2) @(posedge clk);
    reset_release();
    repeat (300) drive_cycle(1'b0);
    repeat (6) drive_cycle(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
